// File: rtl/df_ram1_rd_ctrl_pkg.sv
// Shared constants, FSM encoding and the word-address map for the rec->DF SRAM read sequencer.
// DF_RD_TRANSPOSE_EN selects column-major readout; raster order otherwise.
package df_ram1_rd_ctrl_pkg;

  localparam int DF_MB_WORDS     = 96;
  localparam int DF_LUMA_WORDS   = 64;
  localparam int DF_CHROMA_WORDS = 16;
  localparam int DF_IDX_W        = 7;
  localparam int DF_DATA_W       = 32;
  localparam int DF_ENTRY_W      = DF_IDX_W + DF_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } df_rd_state_e;

  typedef struct packed {
    logic [DF_IDX_W-1:0]  idx;
    logic [DF_DATA_W-1:0] data;
  } df_word_t;

  // Sequence position -> SRAM word address.
  function automatic logic [DF_IDX_W-1:0] df_rd_map(input logic [DF_IDX_W-1:0] i);
`ifdef DF_RD_TRANSPOSE_EN
    // Luma: column-major over 16 rows x 4 words; chroma: 8 rows x 2 words per plane.
    if (i < DF_IDX_W'(DF_LUMA_WORDS)) df_rd_map = {1'b0, i[3:0], i[5:4]};
    else                               df_rd_map = {2'b10, i[4], i[2:0], i[3]};
`else
    df_rd_map = i;
`endif
  endfunction

endpackage

// File: rtl/df_rd_fifo.sv
// Synchronous FIFO with registered storage; head entry is visible the cycle after its push.
module df_rd_fifo #(
  parameter  int WIDTH = 39,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wptr_q, rptr_q;
  logic [CW-1:0]               count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
      wptr_q  <= wptr_q + AW'(push_i);
      rptr_q  <= rptr_q + AW'(pop_i);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/df_ram1_rd_ctrl.sv
// Reads one 96-word macroblock from the rec->DF SRAM and streams it to the deblocking filter.
// Build with DF_RD_TRANSPOSE_EN for column-major address order; ports are identical either way.
module df_ram1_rd_ctrl
  import df_ram1_rd_ctrl_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mb_start_i,
  output logic                 busy_o,
  output logic                 mb_done_o,
  output logic                 ram_cs_n_o,
  output logic                 ram_wr_o,
  output logic [DF_IDX_W-1:0]  ram_addr_o,
  input  logic [DF_DATA_W-1:0] ram_rdata_i,
  output logic                 df_valid_o,
  input  logic                 df_ready_i,
  output logic [DF_DATA_W-1:0] df_data_o,
  output logic [DF_IDX_W-1:0]  df_idx_o,
  output logic                 df_last_o
);

  localparam int NWORDS = DF_MB_WORDS;
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CRW    = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam logic [DF_IDX_W-1:0] LAST_IDX = DF_IDX_W'(NWORDS - 1);

  df_rd_state_e state_q, state_d;
  logic [DF_IDX_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [DF_IDX_W-1:0] addr_q;
  logic [RD_LAT-1:0]   vld_q;
  logic [RD_LAT-1:0][DF_IDX_W-1:0] idx_pipe_q;

  logic [CRW-1:0]        inflight, credit_used;
  logic                  credit_ok, issue, pop;
  logic [FCW-1:0]        fifo_count;
  logic                  fifo_empty, fifo_full;
  logic [DF_ENTRY_W-1:0] fifo_rdata;
  df_word_t              push_w, head_w;

  // Reads already issued but not yet in the FIFO hold a credit until they land.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < RD_LAT; k++) inflight = inflight + CRW'(vld_q[k]);
  end

  assign credit_used = CRW'(fifo_count) + inflight;
  assign credit_ok   = credit_used < CRW'(FIFO_DEPTH);
  assign issue       = (state_q == ST_ISSUE) && credit_ok && !fifo_full;
  assign pop         = df_valid_o && df_ready_i;

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mb_start_i) begin
          state_d  = ST_ISSUE;
          rd_cnt_d = '0;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          if (rd_cnt_q == LAST_IDX) state_d  = ST_DRAIN;
          else                      rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (pop && df_last_o) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= '0;
      addr_q     <= '0;
      vld_q      <= '0;
      idx_pipe_q <= '0;
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      if (issue) addr_q <= df_rd_map(rd_cnt_q);
      vld_q[0]      <= issue;
      idx_pipe_q[0] <= rd_cnt_q;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k]      <= vld_q[k-1];
        idx_pipe_q[k] <= idx_pipe_q[k-1];
      end
    end
  end

  assign push_w.idx  = idx_pipe_q[RD_LAT-1];
  assign push_w.data = ram_rdata_i;

  df_rd_fifo #(
    .WIDTH (DF_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (vld_q[RD_LAT-1]),
    .wdata_i (push_w),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign head_w = df_word_t'(fifo_rdata);

  assign busy_o     = (state_q != ST_IDLE);
  assign mb_done_o  = pop && df_last_o;
  assign ram_cs_n_o = !issue;
  assign ram_wr_o   = 1'b0;
  assign ram_addr_o = issue ? df_rd_map(rd_cnt_q) : addr_q;
  assign df_valid_o = !fifo_empty;
  assign df_data_o  = head_w.data;
  assign df_idx_o   = head_w.idx;
  assign df_last_o  = df_valid_o && (head_w.idx == LAST_IDX);

endmodule

// File: tb/tb_df_ram1_rd_ctrl.sv
// Self-checking bench for df_ram1_rd_ctrl: SRAM model, scoreboard of expected words, per-scenario tasks.
module tb_df_ram1_rd_ctrl;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;
  localparam int NW     = 96;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mb_start = 1'b0;
  logic        busy, mb_done, ram_cs_n, ram_wr, df_valid, df_last;
  logic        df_ready = 1'b1;
  logic [6:0]  ram_addr, df_idx;
  logic [31:0] ram_rdata, df_data;

  df_ram1_rd_ctrl #(.RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mb_start_i  (mb_start),
    .busy_o      (busy),
    .mb_done_o   (mb_done),
    .ram_cs_n_o  (ram_cs_n),
    .ram_wr_o    (ram_wr),
    .ram_addr_o  (ram_addr),
    .ram_rdata_i (ram_rdata),
    .df_valid_o  (df_valid),
    .df_ready_i  (df_ready),
    .df_data_o   (df_data),
    .df_idx_o    (df_idx),
    .df_last_o   (df_last)
  );

  always #5 clk = ~clk;

  // SRAM model: two-cycle read latency
  logic [31:0] mem [0:NW-1];
  logic [6:0]  ap0 = 7'd0, ap1 = 7'd0;
  always @(posedge clk) begin
    if (!ram_cs_n) ap0 <= ram_addr;
    ap1 <= ap0;
  end
  assign ram_rdata = (ap1 < 7'(NW)) ? mem[ap1] : 32'hDEAD_BEEF;

  typedef struct { int idx; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int   addr_log[$];

  int n_tests = 0, n_fail = 0;
  int issued = 0, popped = 0, done_cnt = 0, issue_idx = 0;
  int cyc = 0, start_c = 0, first_valid_cyc = 0, done_cyc = 0;
  bit first_seen = 0;
  int ready_mode = 0;
  bit hold_v = 0;
  logic [31:0] hold_d;
  logic [6:0]  hold_i;

  function automatic int exp_addr(input int i);
`ifdef DF_RD_TRANSPOSE_EN
    int j, b, k;
    if (i < 64) return (i % 16) * 4 + i / 16;
    j = i - 64; b = j / 16; k = j % 16;
    return 64 + 16 * b + (k % 8) * 2 + k / 8;
`else
    return i;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       df_ready = 1'b1;
      1:       df_ready = ~df_ready;
      default: df_ready = 1'b0;
    endcase
  end

  // Monitor: address sequence, hold stability, scoreboard, done pulse, credit bound
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (!ram_cs_n) begin
        n_tests++;
        if (ram_wr !== 1'b0 || issue_idx >= NW || ram_addr !== 7'(exp_addr(issue_idx))) begin
          n_fail++;
          $display("FAIL rd_addr seq=%0d got=%0d exp=%0d wr=%b", issue_idx, ram_addr, exp_addr(issue_idx), ram_wr);
        end
        addr_log.push_back(int'(ram_addr));
        issue_idx++;
        issued++;
      end
      if (hold_v) begin
        n_tests++;
        if (df_valid !== 1'b1 || df_data !== hold_d || df_idx !== hold_i) begin
          n_fail++;
          $display("FAIL hold_stable got v=%b idx=%0d d=%h exp v=1 idx=%0d d=%h", df_valid, df_idx, df_data, hold_i, hold_d);
        end
      end
      hold_v = df_valid && !df_ready;
      hold_d = df_data;
      hold_i = df_idx;
      if (df_valid && !first_seen) begin
        first_seen = 1;
        first_valid_cyc = cyc;
      end
      if (df_valid && df_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word idx=%0d d=%h exp none", df_idx, df_data);
        end else begin
          e = sb.pop_front();
          if (df_idx !== 7'(e.idx) || df_data !== e.data || df_last !== (e.idx == NW-1) ||
              mb_done !== (e.idx == NW-1)) begin
            n_fail++;
            $display("FAIL word got idx=%0d d=%h last=%b done=%b exp idx=%0d d=%h last=%b",
                     df_idx, df_data, df_last, mb_done, e.idx, e.data, e.idx == NW-1);
          end
        end
        popped++;
      end else if (mb_done) begin
        n_tests++; n_fail++;
        $display("FAIL spurious_done got=1 exp=0");
      end
      if (mb_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      n_tests++;
      if (issued - popped > DEPTH) begin
        n_fail++;
        $display("FAIL outstanding got=%0d exp<=%0d", issued - popped, DEPTH);
      end
    end
  end

  task automatic start_mb();
    @(posedge clk); #1;
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    sb.delete();
    addr_log.delete();
    for (int i = 0; i < NW; i++) begin
      exp_t e;
      e.idx = i;
      e.data = mem[exp_addr(i)];
      sb.push_back(e);
    end
    issued = 0; popped = 0; done_cnt = 0; issue_idx = 0; first_seen = 0;
    mb_start = 1'b1;
    start_c = cyc;
    @(posedge clk); #1 mb_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_tests++;
    if (done_cnt == 0) begin
      n_fail++;
      $display("FAIL done_timeout got=none exp=mb_done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mb_start = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, mb_done, ram_cs_n, ram_wr, df_valid, df_last} !== 6'b001000) begin
      n_fail++;
      $display("FAIL reset_ctl got busy=%b done=%b cs_n=%b wr=%b v=%b last=%b exp 0 0 1 0 0 0",
               busy, mb_done, ram_cs_n, ram_wr, df_valid, df_last);
    end
    n_tests++;
    if (ram_addr !== 7'd0 || df_idx !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_idx got addr=%0d idx=%0d exp 0 0", ram_addr, df_idx);
    end
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_stream();
    ready_mode = 0;
    start_mb();
    wait_done(400);
    @(negedge clk);
    n_tests++;
    if (first_valid_cyc - start_c != 1 + RD_LAT + 1) begin
      n_fail++;
      $display("FAIL first_valid_lat got=%0d exp=%0d", first_valid_cyc - start_c, 1 + RD_LAT + 1);
    end
    n_tests++;
    if (done_cyc - first_valid_cyc != NW - 1) begin
      n_fail++;
      $display("FAIL stream_len got=%0d exp=%0d", done_cyc - first_valid_cyc, NW - 1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done_cnt != 1 || popped != NW || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stream_end got busy=%b done=%0d popped=%0d left=%0d exp 0 1 %0d 0",
               busy, done_cnt, popped, sb.size(), NW);
    end
  endtask

  task automatic test_toggle();
    ready_mode = 1;
    start_mb();
    wait_done(800);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done_cnt != 1 || popped != NW || sb.size() != 0) begin
      n_fail++;
      $display("FAIL toggle_end got busy=%b done=%0d popped=%0d left=%0d exp 0 1 %0d 0",
               busy, done_cnt, popped, sb.size(), NW);
    end
    ready_mode = 0;
  endtask

  task automatic test_stall();
    int n = 0;
    ready_mode = 0;
    start_mb();
    while (popped < 30 && n < 500) begin
      @(posedge clk);
      n++;
    end
    ready_mode = 2;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (issued - popped != DEPTH || ram_cs_n !== 1'b1 || df_valid !== 1'b1 || df_idx !== 7'(popped)) begin
      n_fail++;
      $display("FAIL stall got out=%0d cs_n=%b v=%b idx=%0d exp out=%0d cs_n=1 v=1 idx=%0d",
               issued - popped, ram_cs_n, df_valid, df_idx, DEPTH, popped);
    end
    ready_mode = 0;
    wait_done(400);
    n_tests++;
    if (popped != NW || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stall_end got popped=%0d left=%0d exp %0d 0", popped, sb.size(), NW);
    end
  endtask

  task automatic test_start_ignored();
    int n = 0;
    ready_mode = 1;
    start_mb();
    repeat (10) @(posedge clk);
    #1 mb_start = 1'b1;
    @(posedge clk); #1 mb_start = 1'b0;
    while (issued < NW && n < 800) begin
      @(posedge clk);
      n++;
    end
    #1 mb_start = 1'b1;
    @(posedge clk); #1 mb_start = 1'b0;
    wait_done(800);
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done_cnt != 1 || issued != NW || sb.size() != 0) begin
      n_fail++;
      $display("FAIL start_busy got busy=%0b done=%0d issued=%0d left=%0d exp 0 1 %0d 0",
               busy, done_cnt, issued, sb.size(), NW);
    end
    // start coinciding with the final handshake must not relaunch
    ready_mode = 0;
    start_mb();
    n = 0;
    while (!(df_valid && df_idx == 7'(NW-1)) && n < 400) begin
      @(negedge clk);
      n++;
    end
    mb_start = 1'b1;
    @(posedge clk); #1 mb_start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done_cnt != 1 || issued != NW) begin
      n_fail++;
      $display("FAIL start_at_exit got busy=%b done=%0d issued=%0d exp 0 1 %0d", busy, done_cnt, issued, NW);
    end
    start_mb();
    wait_done(400);
    n_tests++;
    if (popped != NW || sb.size() != 0) begin
      n_fail++;
      $display("FAIL second_mb got popped=%0d left=%0d exp %0d 0", popped, sb.size(), NW);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    ready_mode = 0;
    start_mb();
    while (popped < 40 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, mb_done, ram_cs_n, df_valid, df_last} !== 5'b00100 || df_idx !== 7'd0 || ram_addr !== 7'd0) begin
      n_fail++;
      $display("FAIL midreset got busy=%b done=%b cs_n=%b v=%b last=%b idx=%0d addr=%0d exp 0 0 1 0 0 0 0",
               busy, mb_done, ram_cs_n, df_valid, df_last, df_idx, ram_addr);
    end
    sb.delete();
    hold_v = 0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    start_mb();
    wait_done(400);
    n_tests++;
    if (popped != NW || done_cnt != 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL after_reset got popped=%0d done=%0d left=%0d exp %0d 1 0", popped, done_cnt, sb.size(), NW);
    end
  endtask

  task automatic test_addr_map();
    int pos [11] = '{1, 15, 16, 64, 65, 66, 67, 80, 81, 82, 83};
`ifdef DF_RD_TRANSPOSE_EN
    int want [11] = '{4, 60, 1, 64, 66, 68, 70, 80, 82, 84, 86};
`else
    int want [11] = '{1, 15, 16, 64, 65, 66, 67, 80, 81, 82, 83};
`endif
    n_tests++;
    if (addr_log.size() != NW) begin
      n_fail++;
      $display("FAIL addr_count got=%0d exp=%0d", addr_log.size(), NW);
    end else begin
      for (int k = 0; k < 11; k++) begin
        n_tests++;
        if (addr_log[pos[k]] != want[k]) begin
          n_fail++;
          $display("FAIL addr_map i=%0d got=%0d exp=%0d", pos[k], addr_log[pos[k]], want[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_toggle();
    test_stall();
    test_start_ignored();
    test_mid_reset();
    test_addr_map();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
